// File: rtl/pacman_soc_pio_gen2.sv
// Avalon-MM parallel I/O slave: output register with atomic set/clear, synchronised inputs,
// optional edge capture and maskable irq when PACMAN_PIO_EDGE_IRQ_EN is defined.
module pacman_soc_pio_gen2 #(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic                                    wr;
    logic [DATA_WIDTH-1:0]                   wdata;
    logic [DATA_WIDTH-1:0]                   out_reg;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0]  sync_q;
    logic [DATA_WIDTH-1:0]                   sync_last;
    logic [DATA_WIDTH-1:0]                   rd_bits;

    assign wr        = chipselect & ~write_n;
    assign wdata     = writedata[DATA_WIDTH-1:0];
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign out_port  = out_reg;

    generate
        if (DATA_WIDTH < 32) begin : g_unused_wd
            logic unused_wd;
            assign unused_wd = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= RESET_VALUE[DATA_WIDTH-1:0];
        end else if (wr) begin
            case (address)
                3'd0, 3'd1: out_reg <= wdata;
                3'd4:       out_reg <= out_reg | wdata;
                3'd5:       out_reg <= out_reg & ~wdata;
                default:    out_reg <= out_reg;
            endcase
        end
    end

`ifdef PACMAN_PIO_EDGE_IRQ_EN
    logic [DATA_WIDTH-1:0] hist;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] cap_clr;
    logic                  irq_q;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync_last & ~hist;
            1:       edge_det = ~sync_last & hist;
            default: edge_det = sync_last ^ hist;
        endcase
    end

    assign cap_clr = (wr && address == 3'd3) ? wdata : '0;

    // A new edge on a bit being cleared in the same cycle keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist    <= '0;
            irqmask <= '0;
            edgecap <= '0;
            irq_q   <= 1'b0;
        end else begin
            hist    <= sync_last;
            edgecap <= (edgecap & ~cap_clr) | edge_det;
            irq_q   <= |(edgecap & irqmask);
            if (wr && address == 3'd2) begin
                irqmask <= wdata;
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_bits = '0;
        case (address)
            3'd0:    rd_bits = sync_last;
            3'd1:    rd_bits = out_reg;
`ifdef PACMAN_PIO_EDGE_IRQ_EN
            3'd2:    rd_bits = irqmask;
            3'd3:    rd_bits = edgecap;
`endif
            default: rd_bits = '0;
        endcase
    end

    always_comb begin
        readdata = '0;
        readdata[DATA_WIDTH-1:0] = rd_bits;
    end

endmodule

// File: tb/tb_pacman_soc_pio_gen2.sv
// Directed bench for pacman_soc_pio_gen2 (8-bit, reset value A5, rising edge, 2 sync stages).
// Edge/irq scenarios run when PACMAN_PIO_EDGE_IRQ_EN is defined, otherwise the stripped build is checked.
module tb_pacman_soc_pio_gen2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    pacman_soc_pio_gen2 #(
        .DATA_WIDTH (8),
        .RESET_VALUE(32'h000000A5),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tick(2);
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL reset_out_in_reset got %h want a5", out_port);
        end
        reset_n = 1'b1;
        tick(1);
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL reset_out got %h want a5", out_port);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
        bus_read(3'd1, d);
        checks++;
        if (d !== 32'h000000A5) begin
            errors++;
            $display("FAIL reset_rd1 got %h want 000000a5", d);
        end
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd2 got %h want 0", d);
        end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd3 got %h want 0", d);
        end
    endtask

    task automatic test_out_write();
        logic [31:0] d;
        tick(1);
        bus_write(3'd0, 32'hFFFFFF3C);
        checks++;
        if (out_port !== 8'h3C) begin
            errors++;
            $display("FAIL out_data_write got %h want 3c", out_port);
        end
        bus_write(3'd4, 32'h00000001);
        checks++;
        if (out_port !== 8'h3D) begin
            errors++;
            $display("FAIL out_set got %h want 3d", out_port);
        end
        bus_write(3'd5, 32'h00000030);
        checks++;
        if (out_port !== 8'h0D) begin
            errors++;
            $display("FAIL out_clr got %h want 0d", out_port);
        end
        bus_read(3'd1, d);
        checks++;
        if (d !== 32'h0000000D) begin
            errors++;
            $display("FAIL out_rd1 got %h want 0000000d", d);
        end
        bus_read(3'd4, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL outset_rd got %h want 0", d);
        end
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL addr6_rd got %h want 0", d);
        end
        bus_write(3'd7, 32'hFFFFFFFF);
        checks++;
        if (out_port !== 8'h0D) begin
            errors++;
            $display("FAIL addr7_write_ignored got %h want 0d", out_port);
        end
    endtask

`ifdef PACMAN_PIO_EDGE_IRQ_EN
    task automatic test_edge_capture();
        logic [31:0] d;
        tick(1);
        in_port = 8'h04;
        tick(1);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL edge_data_1clk got %h want 0", d);
        end
        tick(1);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h04) begin
            errors++;
            $display("FAIL edge_data_2clk got %h want 04", d);
        end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL edgecap_2clk got %h want 0", d);
        end
        tick(1);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h04) begin
            errors++;
            $display("FAIL edgecap_3clk got %h want 04", d);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_irq_masked got %b want 0", irq);
        end
    endtask

    task automatic test_irq_mask();
        logic [31:0] d;
        bus_write(3'd2, 32'h04);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_same_cycle got %b want 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_mask got %b want 1", irq);
        end
        address    = 3'd3;
        writedata  = 32'h04;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h04) begin
            errors++;
            $display("FAIL edgecap_read_during_clear got %h want 04", readdata);
        end
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_clear_edge got %b want 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_clear got %b want 0", irq);
        end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL edgecap_after_clear got %h want 0", d);
        end
    endtask

    task automatic test_falling_ignored();
        logic [31:0] d;
        in_port = 8'h00;
        tick(4);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL falling_edgecap got %h want 0", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL falling_irq got %b want 0", irq);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        in_port = 8'h04;
        tick(4);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL setwins_pre_irq got %b want 1", irq);
        end
        in_port = 8'h00;
        tick(4);
        in_port = 8'h04;
        tick(2);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h04) begin
            errors++;
            $display("FAIL setwins_edgecap got %h want 04", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL setwins_irq got %b want 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL setwins_irq_next got %b want 1", irq);
        end
    endtask
`else
    task automatic test_no_edge_irq();
        logic [31:0] d;
        bus_write(3'd2, 32'hFF);
        in_port = 8'h5A;
        tick(2);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL noirq_data got %h want 5a", d);
        end
        in_port = 8'h81;
        tick(1);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL noirq_data_1clk got %h want 5a", d);
        end
        tick(1);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h81) begin
            errors++;
            $display("FAIL noirq_data_2clk got %h want 81", d);
        end
        tick(2);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL noirq_irq got %b want 0", irq);
        end
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL noirq_rd2 got %h want 0", d);
        end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL noirq_rd3 got %h want 0", d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_out_write();
`ifdef PACMAN_PIO_EDGE_IRQ_EN
        test_edge_capture();
        test_irq_mask();
        test_falling_ignored();
        test_set_wins();
`else
        test_no_edge_irq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pacman_soc_pio_gen2.md
# pacman_soc_pio_gen2

Parametrised Avalon-MM parallel I/O slave for the Pacman SoC, the successor to the single-bit output-only PIO used for controller chip-select and reset lines. It provides a DATA_WIDTH output register with atomic bit set/clear, a synchronised input path, per-bit edge capture and a maskable level interrupt. It sits on the system interconnect as a zero-wait-state slave, one instance per I/O group (HPI control lines, keycode inputs, LEDs).

## Interface
- DATA_WIDTH, 8: width of in_port/out_port, legal 1..32.
- RESET_VALUE, 0: out_port value after reset, truncated to DATA_WIDTH.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge captured.
- SYNC_STAGES, 2: input synchroniser depth, legal 2..4.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_WIDTH ignored.
- readdata  out  32  read data, combinational from address; bits above DATA_WIDTH read 0.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- out_port  out  DATA_WIDTH  registered outputs.
- irq  out  1  registered interrupt request, active-high.

## Operation
- Write strobe: chipselect & ~write_n, single cycle, no wait states.
- Address 0 DATA: read = synchronised in_port (last synchroniser stage); write loads out_reg.
- Address 1 OUT: read = out_reg; write loads out_reg (alias of DATA write).
- Address 2 IRQMASK: read/write, reset 0.
- Address 3 EDGECAP: read = capture bits; write-1-to-clear per bit, 0 bits unaffected.
- Address 4 OUTSET: write: out_reg |= writedata; read 0.
- Address 5 OUTCLR: write: out_reg &= ~writedata; read 0.
- Addresses 6, 7: reads 0, writes ignored.
- Synchroniser: SYNC_STAGES flops per bit, then one history flop; edge = per-bit compare of last stage vs history per EDGE_TYPE.
- Edge capture bit sets on detected edge and holds until cleared; edge and clear on the same bit in the same cycle: set wins.
- irq_next = |(edgecap & irqmask); irq registered from irq_next.
- out_port = out_reg directly (no extra pipeline).
- Reset (any time, including mid-transfer): out_reg = RESET_VALUE, irqmask = 0, edgecap = 0, synchroniser and history = 0, irq = 0. First cycle after reset release must not report a spurious edge from a zero history on a high input when EDGE_TYPE = 0: history and stages load in_port-derived values normally, so a steady-high input produces exactly one rising capture; this is the required, documented behaviour.

## Timing
- Writes to out_reg: out_port changes on the clk edge that samples the write.
- readdata valid in the same cycle as address/chipselect (combinational).
- in_port change to DATA readback: SYNC_STAGES clocks.
- in_port edge to EDGECAP bit set: SYNC_STAGES + 1 clocks.
- EDGECAP/IRQMASK update to irq change: 1 clock.
- Clearing the last pending masked bit: irq deasserts 1 clock after the clear write.
- Read of EDGECAP in the cycle a clear is written returns the pre-clear value.

## Configuration
- PACMAN_PIO_EDGE_IRQ_EN defined: edge detector, EDGECAP, IRQMASK and irq logic present as above.
- Not defined: history flop, EDGECAP and IRQMASK removed; addresses 2 and 3 read 0, writes ignored; irq tied to 0; synchroniser and DATA/OUT/OUTSET/OUTCLR unchanged.

## Test plan
- Reset with RESET_VALUE = 8'hA5, DATA_WIDTH = 8 -> out_port = 8'hA5, irq = 0, reads of addresses 1/2/3 = 32'h000000A5/0/0.
- Write 32'hFFFFFF3C to address 0, then OUTSET 8'h01, then OUTCLR 8'h30 -> out_port 8'h3C, 8'h3D, 8'h0D; address 1 reads 32'h0000000D.
- in_port 8'h00 -> 8'h04 with EDGE_TYPE = 0, SYNC_STAGES = 2 -> DATA reads 8'h04 after 2 clocks, EDGECAP bit 2 set after 3 clocks, irq stays 0 (mask 0).
- IRQMASK = 8'h04 with EDGECAP bit 2 pending -> irq = 1 one clock later; write 8'h04 to EDGECAP -> irq = 0 one clock later.
- Rising edge on bit 2 arriving in the same cycle as EDGECAP clear of bit 2 -> bit 2 remains 1, irq remains 1.
- Build without PACMAN_PIO_EDGE_IRQ_EN, toggle in_port and write address 2 = 8'hFF -> irq = 0, addresses 2/3 read 0, DATA readback still tracks in_port.
